// File: rtl/alu_sequencer_if.sv
// Program memory read port between the sequencer (master) and memory (slave).
// Valid-handshaked: data is taken when mem_rd and mem_valid are both high.
interface alu_sequencer_if;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       mem_valid;

    modport master (output mem_addr, mem_rd, input mem_data, mem_valid);
    modport slave  (input mem_addr, mem_rd, output mem_data, mem_valid);
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute control path for the 8-bit ALU.
// It owns ACC, CY, R0-R3 and PC, and writes the ALU result back in EXEC.
//
// state       | meaning
// S_FETCH     | request the opcode byte at PC (only while run is high)
// S_FETCH_IMM | request the immediate byte of LDI/JMP/JC at PC
// S_EXEC      | one-cycle writeback or branch
// S_HALT      | HLT executed; parked until reset
module alu_sequencer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    alu_sequencer_if.master        mem,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_r,
    output logic [2:0]             alu_op,
    output logic                   alu_cy,
    input  logic [7:0]             alu_res,
    input  logic                   alu_cy_out,
    output logic [7:0]             acc,
    output logic                   cy,
    output logic                   halted
);
    typedef enum logic [1:0] {S_FETCH, S_FETCH_IMM, S_EXEC, S_HALT} state_t;

    state_t     state, state_nxt;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] imm;
    logic [7:0] regs [4];
    logic       rd_req;
    logic       accept;
    logic       two_byte;
    logic [3:0] opc;
    logic [1:0] unused_ir;

    assign opc       = ir[7:4];
    assign unused_ir = ir[3:2];
    assign accept    = rd_req & mem.mem_valid;
    assign two_byte  = (mem.mem_data[7:4] == 4'h8) || (mem.mem_data[7:4] == 4'hB) ||
                       (mem.mem_data[7:4] == 4'hC);

    assign mem.mem_addr = pc;
    // rd is forced low while reset is held, even though the state is already S_FETCH
    assign mem.mem_rd   = rd_req & rst_n;

    assign alu_a  = acc;
    assign alu_r  = regs[ir[1:0]];
    assign alu_op = ir[6:4];
    assign alu_cy = cy;
    assign halted = (state == S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        case (state)
            S_FETCH: begin
                rd_req = run;
                if (accept) state_nxt = two_byte ? S_FETCH_IMM : S_EXEC;
            end
            S_FETCH_IMM: begin
                rd_req = 1'b1;
                if (accept) state_nxt = S_EXEC;
            end
            S_EXEC:  state_nxt = (opc == 4'hF) ? S_HALT : S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= 8'h00;
            ir  <= 8'h00;
            imm <= 8'h00;
            acc <= 8'h00;
            cy  <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (accept) begin
                        ir <= mem.mem_data;
                        pc <= pc + 8'd1;
                    end
                end
                S_FETCH_IMM: begin
                    if (accept) begin
                        imm <= mem.mem_data;
                        pc  <= pc + 8'd1;
                    end
                end
                S_EXEC: begin
                    case (opc)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                            acc <= alu_res;
                            cy  <= alu_cy_out;
                        end
                        4'h6: acc <= alu_res;
                        4'h7: regs[ir[1:0]] <= acc;
                        4'h8: acc <= imm;
                        4'h9: cy  <= 1'b0;
                        4'hA: cy  <= 1'b1;
                        4'hB: pc  <= imm;
                        4'hC: if (cy) pc <= imm;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a program memory with programmable wait
// states, a reference ALU, an ALU vector table and hand-written control sequences.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] alu_a, alu_r, alu_res, acc;
    logic [2:0] alu_op;
    logic       alu_cy, alu_cy_out, cy, halted;

    alu_sequencer_if mem_if();

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mem(mem_if.master),
        .alu_a(alu_a), .alu_r(alu_r), .alu_op(alu_op), .alu_cy(alu_cy),
        .alu_res(alu_res), .alu_cy_out(alu_cy_out),
        .acc(acc), .cy(cy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Program memory: data valid after wait_cfg stalled cycles per read
    logic [7:0] prog [256];
    int         wait_cfg = 0;
    int         wait_cnt = 0;

    assign mem_if.mem_data  = prog[mem_if.mem_addr];
    assign mem_if.mem_valid = (wait_cnt >= wait_cfg);

    always @(posedge clk) begin
        if (!rst_n)                                      wait_cnt <= 0;
        else if (mem_if.mem_rd && !mem_if.mem_valid)     wait_cnt <= wait_cnt + 1;
        else if (mem_if.mem_rd)                          wait_cnt <= 0;
    end

    // Reference ALU: ADD/SUB with carry/borrow in, logic ops clear carry out
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'h000;
        case (alu_op)
            3'd0: alu_wide = {1'b0, alu_a} + {1'b0, alu_r} + {8'h00, alu_cy};
            3'd1: alu_wide = {1'b0, alu_a} - {1'b0, alu_r} - {8'h00, alu_cy};
            3'd2: alu_wide = {1'b0, alu_a | alu_r};
            3'd3: alu_wide = {1'b0, alu_a & alu_r};
            3'd4: alu_wide = {1'b0, alu_a ^ alu_r};
            3'd5: alu_wide = {1'b0, ~alu_a};
            default: alu_wide = {1'b0, alu_r};
        endcase
    end
    assign alu_res    = alu_wide[7:0];
    assign alu_cy_out = alu_wide[8];

    // Stall stability and quiet-bus monitor, sampled on the falling edge
    logic       prev_stall = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    int         stall_viol = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!mem_if.mem_rd || mem_if.mem_addr != prev_addr))
                stall_viol <= stall_viol + 1;
            if (halted && mem_if.mem_rd)
                stall_viol <= stall_viol + 1;
            prev_stall <= mem_if.mem_rd && !mem_if.mem_valid;
            prev_addr  <= mem_if.mem_addr;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'hF0;
    endtask

    task automatic apply_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        #1;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("halt_reached", {15'h0, halted}, 16'h1);
    endtask

    // LDI 0xFF; ST R0; LDI 0x01; CLC; ADD R0; HLT
    task automatic load_carry_prog();
        clear_prog();
        prog[0] = 8'h80; prog[1] = 8'hFF; prog[2] = 8'h70;
        prog[3] = 8'h80; prog[4] = 8'h01; prog[5] = 8'h90; prog[6] = 8'h00;
        prog[7] = 8'hF0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] r;
        logic       cy_in;
        logic [2:0] op;
        logic [7:0] exp_acc;
        logic       exp_cy;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int cyc;
        int bad;

        vecs[0] = '{8'h12, 8'h34, 1'b0, 3'd0, 8'h46, 1'b0};
        vecs[1] = '{8'h80, 8'h80, 1'b1, 3'd0, 8'h01, 1'b1};
        vecs[2] = '{8'h10, 8'h01, 1'b0, 3'd1, 8'h0F, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 3'd1, 8'hFF, 1'b1};
        vecs[4] = '{8'hF0, 8'h0F, 1'b1, 3'd2, 8'hFF, 1'b0};
        vecs[5] = '{8'hF0, 8'h3C, 1'b0, 3'd3, 8'h30, 1'b0};
        vecs[6] = '{8'hAA, 8'hFF, 1'b0, 3'd4, 8'h55, 1'b0};
        vecs[7] = '{8'h5A, 8'h00, 1'b1, 3'd5, 8'hA5, 1'b0};
        vecs[8] = '{8'h11, 8'h77, 1'b1, 3'd6, 8'h77, 1'b1};
        vecs[9] = '{8'h11, 8'h77, 1'b0, 3'd6, 8'h77, 1'b0};

        clear_prog();
        rst_n = 1'b0;
        #1;
        check("rst_mem_rd",   {15'h0, mem_if.mem_rd}, 16'h0);
        check("rst_mem_addr", {8'h0, mem_if.mem_addr}, 16'h0);
        check("rst_acc_cy",   {7'h0, cy, acc}, 16'h0);
        check("rst_halted",   {15'h0, halted}, 16'h0);

        // ALU vector table: LDI r; ST R1; LDI a; CLC/SEC; op R1; HLT
        for (int v = 0; v < 10; v++) begin
            clear_prog();
            prog[0] = 8'h80; prog[1] = vecs[v].r; prog[2] = 8'h71;
            prog[3] = 8'h80; prog[4] = vecs[v].a;
            prog[5] = vecs[v].cy_in ? 8'hA0 : 8'h90;
            prog[6] = {1'b0, vecs[v].op, 4'h1};
            apply_reset();
            run_to_halt(200, cyc);
            check($sformatf("vec%0d_acc", v), {8'h0, acc}, {8'h0, vecs[v].exp_acc});
            check($sformatf("vec%0d_cy", v), {15'h0, cy}, {15'h0, vecs[v].exp_cy});
        end

        // Carry chain, zero-wait: 8 bytes + 6 EXEC cycles
        load_carry_prog();
        apply_reset();
        check("first_rd", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0100);
        run_to_halt(200, cyc);
        check("carry_acc_cy", {7'h0, cy, acc}, 16'h0100);
        check("carry_cycles", cyc[15:0], 16'd14);

        // Carry chain continued: LDI 0x00; ADD R0 with carry in
        load_carry_prog();
        prog[7] = 8'h80; prog[8] = 8'h00; prog[9] = 8'h00; prog[10] = 8'hF0;
        apply_reset();
        run_to_halt(200, cyc);
        check("carry2_acc_cy", {7'h0, cy, acc}, 16'h0100);

        // Borrow, then LD R1 keeps CY
        clear_prog();
        prog[0] = 8'h80; prog[1] = 8'h05; prog[2] = 8'h71;
        prog[3] = 8'h80; prog[4] = 8'h03; prog[5] = 8'hA0; prog[6] = 8'h11;
        apply_reset();
        run_to_halt(200, cyc);
        check("borrow_acc_cy", {7'h0, cy, acc}, 16'h01FD);
        prog[7] = 8'h61; prog[8] = 8'hF0;
        apply_reset();
        run_to_halt(200, cyc);
        check("ld_keeps_cy", {7'h0, cy, acc}, 16'h0105);

        // Branches: CLC; JC 0x40 falls through, SEC; JC 0x40 taken, JMP 0x10
        clear_prog();
        prog[0] = 8'h90; prog[1] = 8'hC0; prog[2] = 8'h40;
        prog[3] = 8'hA0; prog[4] = 8'hC0; prog[5] = 8'h40;
        prog[8'h40] = 8'hB0; prog[8'h41] = 8'h10;
        apply_reset();
        step(5);
        check("jc_not_taken", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0103);
        step(5);
        check("jc_taken", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0140);
        step(3);
        check("jmp", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0110);
        run_to_halt(50, cyc);

        // Wait states: 3 extra cycles per byte, same result
        wait_cfg = 3;
        load_carry_prog();
        apply_reset();
        run_to_halt(400, cyc);
        check("wait_acc_cy", {7'h0, cy, acc}, 16'h0100);
        check("wait_cycles", cyc[15:0], 16'd38);
        check("stall_stable", stall_viol[15:0], 16'h0);

        // Reset while a stalled fetch has mem_rd high
        load_carry_prog();
        apply_reset();
        step(10);
        check("midfetch_pre", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0102);
        check("midfetch_acc", {8'h0, acc}, 16'h00FF);
        rst_n = 1'b0;
        #1;
        check("midfetch_rst_bus", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0000);
        check("midfetch_rst_state", {6'h0, halted, cy, acc}, 16'h0000);
        @(posedge clk);
        wait_cfg = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midfetch_restart", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0100);
        run_to_halt(200, cyc);
        check("midfetch_final", {7'h0, cy, acc}, 16'h0100);

        // RUN dropped during FETCH_IMM of LDI
        clear_prog();
        prog[0] = 8'h80; prog[1] = 8'h42; prog[2] = 8'h80; prog[3] = 8'h99;
        apply_reset();
        step(1);
        run = 1'b0;
        #1;
        check("run_low_imm_rd", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0101);
        step(2);
        check("run_low_done", {7'h0, mem_if.mem_rd, acc}, 16'h0042);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (mem_if.mem_rd || mem_if.mem_addr != 8'h02) bad++;
        end
        check("run_low_idle", bad[15:0], 16'h0);
        run = 1'b1;
        run_to_halt(50, cyc);
        check("run_resume_acc", {8'h0, acc}, 16'h0099);

        // HLT keeps the bus quiet
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (mem_if.mem_rd || !halted) bad++;
        end
        check("halt_quiet", bad[15:0], 16'h0);

        // PC wrap: JMP 0xFF, then JMP at 0xFF takes its immediate from 0x00
        clear_prog();
        prog[0] = 8'hB0; prog[1] = 8'hFF; prog[8'hFF] = 8'hB0;
        apply_reset();
        step(3);
        check("wrap_at_ff", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h01FF);
        step(1);
        check("wrap_imm_addr", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0100);
        step(1);
        check("wrap_exec", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h0001);
        step(1);
        check("wrap_target", {7'h0, mem_if.mem_rd, mem_if.mem_addr}, 16'h01B0);
        run_to_halt(50, cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
